periph_burst_sequencer: RTL
===========================

Name: periph_burst_sequencer

Overview:
- Drains one peripheral RX FIFO per transaction into the FT601 TX stream.
- Each transaction is a framed burst: header word, up to MAX_BURST payload words, then a trailer word.
- Sits between the 8 peripheral RX FIFOs and the FT601 TX path, and consumes the arbiter's grant.
- Pulses read_periph_data once per completed burst so the arbiter advances to the next peripheral.

Parameters:
- MAX_BURST, 64: maximum payload words per burst. Legal range 1..65535.
- CNT_W, $clog2(MAX_BURST+1): payload counter width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_fifo_empty  in  8  per-peripheral RX FIFO empty flags. FIFOs are first-word-fall-through.
- rx_fifo_rdata  in  256  flattened FIFO heads; peripheral i occupies bits [32*i+31:32*i].
- rx_fifo_rd_en  out  8  one-hot pop strobes.
- grant  in  3  peripheral index selected by the arbiter.
- read_periph_data  out  1  one-cycle pulse when a burst completes; advances the arbiter.
- tx_data  out  32  word to the FT601 TX path.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  FT601 TX path accepts the word.
- tx_last  out  1  marks the trailer word.
- busy  out  1  high in every state except IDLE.
- cur_periph  out  3  latched peripheral index for the current burst.

Behaviour:
- States: IDLE, HEADER, DATA, TRAILER.
- Reset values: state = IDLE, sel = 0, cnt = 0, all outputs 0, tx_data = 0.
- Reset is also taken mid-burst: return to IDLE immediately; no trailer is emitted; no pulse on read_periph_data.
- IDLE:
  - tx_valid = 0.
  - If rx_fifo_empty[grant] == 0, latch sel = grant and go to HEADER.
  - Otherwise stay in IDLE; grant is re-sampled every cycle.
- HEADER:
  - tx_valid = 1; tx_data = {8'hA5, 13'b0, sel[2:0], 8'h00}; tx_last = 0.
  - On tx_ready, go to DATA with cnt = 0.
- DATA:
  - tx_valid = ~rx_fifo_empty[sel]; tx_data = rx_fifo_rdata slice for sel.
  - rx_fifo_rd_en[sel] = tx_valid & tx_ready; all other rd_en bits are 0.
  - On a pop, cnt increments.
  - If cnt+1 == MAX_BURST on a pop, go to TRAILER.
  - Else if rx_fifo_empty[sel] == 1 and cnt > 0, go to TRAILER; this is the empty-terminated burst, with no pop that cycle.
  - cnt == 0 with empty cannot occur: the FIFO was non-empty at latch and only this block pops it. If it does occur, wait.
- TRAILER:
  - tx_valid = 1; tx_last = 1.
  - tx_data = {8'h5A, 5'b0, sel[2:0], 16-bit zero-extended cnt}.
  - On tx_ready: read_periph_data = 1 for exactly that cycle, then go to IDLE.
- Handshake rules:
  - A word transfers only on the cycle where tx_valid & tx_ready are both high.
  - While tx_valid = 1 and tx_ready = 0, tx_data, tx_last and tx_valid stay stable.
  - tx_valid/tx_data are combinational from state, sel and the FIFO head. No combinational path from tx_ready to tx_valid.
- Grant handling:
  - grant changes during a burst are ignored; sel stays latched until IDLE.
- Latency and throughput:
  - IDLE→HEADER takes 1 cycle.
  - Minimum burst is header + 1 payload + trailer = 3 transfer cycles plus 1 IDLE cycle.
  - Back-to-back bursts have one IDLE bubble between trailer and next header.
- Counter width rules:
  - cnt is CNT_W bits; it never exceeds MAX_BURST and never wraps.
  - The trailer count field is zero-extended to 16 bits.
- busy = (state != IDLE).
- cur_periph = sel.

Test Plan:
- Single-word burst:
  - Stimulus: FIFO 3 holds one word 0xDEADBEEF, grant = 3, tx_ready = 1.
  - Required: tx stream 0xA5000300, 0xDEADBEEF, 0x5A030001 (tx_last = 1); rd_en[3] pulses once; read_periph_data pulses 1 cycle after the trailer handshake edge.
- Burst cap:
  - Stimulus: MAX_BURST = 4, FIFO 0 holds 10 words.
  - Required: header, 4 payload words, trailer 0x5A000004, then IDLE; 6 words remain; a second burst on the same grant emits 4 more words.
- Backpressure:
  - Stimulus: tx_ready toggles 1,0,0,1 during DATA.
  - Required: tx_data stable while stalled; no rd_en while tx_ready = 0; payload order preserved; trailer count correct.
- Empty grant:
  - Stimulus: grant = 5 with rx_fifo_empty[5] = 1 for 10 cycles.
  - Required: stays in IDLE, tx_valid = 0, busy = 0; grant then switches to nonempty FIFO 2, and HEADER with id 2 appears next cycle.
- Reset mid-burst:
  - Stimulus: rst = 1 during DATA after 2 pops.
  - Required: next cycle tx_valid = 0, busy = 0, rd_en = 0, no trailer, no read_periph_data pulse.
- Grant change mid-burst:
  - Stimulus: grant changes 1→6 during DATA.
  - Required: only rd_en[1] asserts; header and trailer id remain 1.

Source files
------------

// File: rtl/periph_burst_sequencer.sv
// rtl/periph_burst_sequencer.sv - framed burst drain of one peripheral RX FIFO into the FT601 TX stream
module periph_burst_sequencer #(
  parameter  int MAX_BURST = 64,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_fifo_empty,
  input  logic [255:0] rx_fifo_rdata,
  output logic [7:0]   rx_fifo_rd_en,
  input  logic [2:0]   grant,
  output logic         read_periph_data,
  output logic [31:0]  tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  output logic [2:0]   cur_periph
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_TRAILER
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rpd_q, rpd_d;

  logic [31:0]      head;
  logic             empty_sel;
  logic [CNT_W-1:0] cnt_inc;

  assign head      = rx_fifo_rdata[{sel_q, 5'b0} +: 32];
  assign empty_sel = rx_fifo_empty[sel_q];
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      rpd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rpd_q   <= rpd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    rpd_d         = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = '0;
    tx_last       = 1'b0;
    rx_fifo_rd_en = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_fifo_empty[grant]) begin
          sel_d   = grant;
          state_d = S_HEADER;
        end
      end

      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = {8'hA5, 13'b0, sel_q, 8'h00};
        if (tx_ready) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        tx_valid = ~empty_sel;
        tx_data  = head;
        if (!empty_sel && tx_ready) begin
          rx_fifo_rd_en = 8'd1 << sel_q;
          cnt_d         = cnt_inc;
          if (cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d = S_TRAILER;
          end
        end else if (empty_sel && (cnt_q != '0)) begin
          // FIFO ran dry mid-burst: close the frame with what was sent
          state_d = S_TRAILER;
        end
      end

      S_TRAILER: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = {8'h5A, 5'b0, sel_q, 16'(cnt_q)};
        if (tx_ready) begin
          rpd_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign read_periph_data = rpd_q;
  assign busy             = (state_q != S_IDLE);
  assign cur_periph       = sel_q;

endmodule
